// File: rtl/md_audio_pkg.sv
// Shared widths, the stereo sample type and the saturating adder for the md_audio_mixer slice.
package md_audio_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int FM_W       = 9;
    localparam int ACC_W      = 18;
    localparam int FIFO_DEPTH = 2;
    localparam int PROD_W     = 28;
    localparam int MIX_W      = 21;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] l;
        logic signed [SAMPLE_W-1:0] r;
    } stereo_t;

    localparam logic signed [MIX_W:0] SAT_MAX = 22'sd32767;
    localparam logic signed [MIX_W:0] SAT_MIN = -22'sd32768;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [MIX_W-1:0] a,
                                                         input logic signed [MIX_W-1:0] b);
        logic signed [MIX_W:0] s;
        s = {a[MIX_W-1], a} + {b[MIX_W-1], b};
        if (s > SAT_MAX) return 16'sh7fff;
        if (s < SAT_MIN) return 16'sh8000;
        return s[SAMPLE_W-1:0];
    endfunction
endpackage

// File: rtl/md_audio_fifo2.sv
// Two-entry valid/ready FIFO for stereo samples; a write into a full FIFO is dropped and flagged.
module md_audio_fifo2
    import md_audio_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    wrVld_i,
    input  stereo_t wrData_i,
    input  logic    rdReady_i,
    output logic    rdVld_o,
    output stereo_t rdData_o,
    output logic    drop_o
);
    stereo_t    mem_q [2];
    stereo_t    mem_d [2];
    logic [1:0] cnt_q, cnt_d, space;
    logic       pop, accept;

    // A pop on the same edge frees its slot before the write is placed.
    always_comb begin
        pop    = (cnt_q != 2'd0) && rdReady_i;
        space  = cnt_q - {1'b0, pop};
        accept = wrVld_i && (space != 2'(FIFO_DEPTH));
        drop_o = wrVld_i && !accept;
        mem_d  = mem_q;
        if (pop) mem_d[0] = mem_q[1];
        if (accept) mem_d[space[0]] = wrData_i;
        cnt_d  = space + {1'b0, accept};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    assign rdVld_o  = (cnt_q != 2'd0);
    assign rdData_o = mem_q[0];
endmodule

// File: rtl/md_audio_mixer.sv
// FM/PSG audio mixer: boxcar-averages MOL/MOR per FM period, mixes with PSG, saturates, buffers in a FIFO.
// Optional DC blocker per channel when MD_AUDIO_MIXER_DC_BLOCK_EN is defined.
module md_audio_mixer
    import md_audio_pkg::*;
#(
    parameter int FM_PERIOD = 144,
    parameter int FM_GAIN   = 32,
    parameter int PSG_GAIN  = 64,
    parameter int PSG_BIAS  = 0
) (
    input  logic                       MCLK,
    input  logic                       SRES,
    input  logic signed [FM_W-1:0]     MOL,
    input  logic signed [FM_W-1:0]     MOR,
    input  logic [SAMPLE_W-1:0]        PSG,
    input  logic                       MUTE,
    input  logic                       AUD_READY,
    output logic                       AUD_VALID,
    output logic signed [SAMPLE_W-1:0] AUD_L,
    output logic signed [SAMPLE_W-1:0] AUD_R,
    output logic                       OVF,
    output logic [7:0]                 DROP_CNT
);
    localparam logic [7:0]               LAST_CNT   = 8'(FM_PERIOD - 1);
    localparam logic signed [PROD_W-1:0] FM_GAIN_S  = PROD_W'(FM_GAIN);
    localparam logic signed [PROD_W-1:0] PSG_GAIN_S = PROD_W'(PSG_GAIN);
    localparam logic [SAMPLE_W:0]        PSG_BIAS_X = (SAMPLE_W+1)'(PSG_BIAS);

    logic [7:0]                 winCnt_q, winCnt_d;
    logic                       lastCycle;
    logic signed [FM_W-1:0]     fmIn [2];
    logic signed [ACC_W-1:0]    acc_q [2], acc_d [2], accSum [2];
    logic signed [ACC_W-1:0]    s1Acc_q [2];
    logic [SAMPLE_W-1:0]        s1Psg_q;
    logic                       s1Mute_q, s1Vld_q;
    logic signed [SAMPLE_W:0]   psgDiff;
    logic signed [MIX_W-1:0]    s2Fm_q [2], s2Fm_d [2];
    logic signed [MIX_W-1:0]    s2Psg_q, s2Psg_d;
    logic                       s2Mute_q, s2Vld_q;
    logic signed [SAMPLE_W-1:0] mix [2];
    logic                       wrVld, drop;
    stereo_t                    wrData, head;
    logic                       ovf_q;
    logic [7:0]                 dropCnt_q;

    assign fmIn[0]   = MOL;
    assign fmIn[1]   = MOR;
    assign lastCycle = (winCnt_q == LAST_CNT);

    // The closing window includes the current cycle's FM value, so stage1 takes acc+input.
    always_comb begin
        winCnt_d = lastCycle ? 8'd0 : winCnt_q + 8'd1;
        psgDiff  = $signed({1'b0, s1Psg_q} - PSG_BIAS_X);
        s2Psg_d  = MIX_W'((PROD_W'(psgDiff) * PSG_GAIN_S) >>> 8);
        for (int c = 0; c < 2; c++) begin
            accSum[c] = acc_q[c] + ACC_W'(fmIn[c]);
            acc_d[c]  = lastCycle ? '0 : accSum[c];
            s2Fm_d[c] = MIX_W'((PROD_W'(s1Acc_q[c]) * FM_GAIN_S) >>> 8);
            mix[c]    = s2Mute_q ? '0 : sat16(s2Fm_q[c], s2Psg_q);
        end
    end

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            winCnt_q  <= '0;
            s1Psg_q   <= '0;
            s1Mute_q  <= 1'b0;
            s1Vld_q   <= 1'b0;
            s2Psg_q   <= '0;
            s2Mute_q  <= 1'b0;
            s2Vld_q   <= 1'b0;
            ovf_q     <= 1'b0;
            dropCnt_q <= '0;
            for (int c = 0; c < 2; c++) begin
                acc_q[c]   <= '0;
                s1Acc_q[c] <= '0;
                s2Fm_q[c]  <= '0;
            end
        end else begin
            winCnt_q <= winCnt_d;
            s1Vld_q  <= lastCycle;
            s2Vld_q  <= s1Vld_q;
            for (int c = 0; c < 2; c++) begin
                acc_q[c] <= acc_d[c];
                if (lastCycle) s1Acc_q[c] <= accSum[c];
                if (s1Vld_q)   s2Fm_q[c]  <= s2Fm_d[c];
            end
            if (lastCycle) begin
                s1Psg_q  <= PSG;
                s1Mute_q <= MUTE;
            end
            if (s1Vld_q) begin
                s2Psg_q  <= s2Psg_d;
                s2Mute_q <= s1Mute_q;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (dropCnt_q != 8'hff) dropCnt_q <= dropCnt_q + 8'd1;
            end
        end
    end

`ifdef MD_AUDIO_MIXER_DC_BLOCK_EN
    logic signed [SAMPLE_W-1:0] s3_q [2];
    logic                       s3Vld_q;
    logic signed [ACC_W-1:0]    xPrev_q [2], yPrev_q [2];
    logic signed [ACC_W-1:0]    dcDiff [2], dcLeak [2];
    logic signed [SAMPLE_W-1:0] dcOut [2];

    // Blocker state advances only when a window sample passes through.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            dcDiff[c] = ACC_W'(s3_q[c]) - xPrev_q[c];
            dcLeak[c] = yPrev_q[c] - (yPrev_q[c] >>> 8);
            dcOut[c]  = sat16(MIX_W'(dcDiff[c]), MIX_W'(dcLeak[c]));
        end
    end

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            s3Vld_q <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                s3_q[c]    <= '0;
                xPrev_q[c] <= '0;
                yPrev_q[c] <= '0;
            end
        end else begin
            s3Vld_q <= s2Vld_q;
            for (int c = 0; c < 2; c++) begin
                if (s2Vld_q) s3_q[c] <= mix[c];
                if (s3Vld_q) begin
                    xPrev_q[c] <= ACC_W'(s3_q[c]);
                    yPrev_q[c] <= ACC_W'(dcOut[c]);
                end
            end
        end
    end

    assign wrVld  = s3Vld_q;
    assign wrData = {dcOut[0], dcOut[1]};
`else
    assign wrVld  = s2Vld_q;
    assign wrData = {mix[0], mix[1]};
`endif

    md_audio_fifo2 uFifo (
        .clk_i    (MCLK),
        .rst_ni   (SRES),
        .wrVld_i  (wrVld),
        .wrData_i (wrData),
        .rdReady_i(AUD_READY),
        .rdVld_o  (AUD_VALID),
        .rdData_o (head),
        .drop_o   (drop)
    );

    assign AUD_L    = head.l;
    assign AUD_R    = head.r;
    assign OVF      = ovf_q;
    assign DROP_CNT = dropCnt_q;
endmodule

// File: tb/tb_md_audio_mixer.sv
// Self-checking bench for md_audio_mixer: vector table, hand sequences and a randomized run
// compared against a window-level reference model. Honours MD_AUDIO_MIXER_DC_BLOCK_EN.
module tb_md_audio_mixer;
    localparam int P    = 144;
    localparam int FMG  = 32;
    localparam int PSGG = 64;
`ifdef MD_AUDIO_MIXER_DC_BLOCK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              MCLK = 1'b0;
    logic              SRES = 1'b0;
    logic signed [8:0] mol, mor;
    logic [15:0]       psg;
    logic              mute, ready;
    logic              audValid, ovf;
    logic signed [15:0] audL, audR;
    logic [7:0]        dropCnt;

    logic signed [8:0] satMol, satMor;
    logic              satValid, satOvf;
    logic signed [15:0] satL, satR;
    logic [7:0]        satDrop;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    md_audio_mixer dut (
        .MCLK(MCLK), .SRES(SRES), .MOL(mol), .MOR(mor), .PSG(psg), .MUTE(mute),
        .AUD_READY(ready), .AUD_VALID(audValid), .AUD_L(audL), .AUD_R(audR),
        .OVF(ovf), .DROP_CNT(dropCnt)
    );

    md_audio_mixer #(.FM_GAIN(1023)) dutSat (
        .MCLK(MCLK), .SRES(SRES), .MOL(satMol), .MOR(satMor), .PSG(16'h0000), .MUTE(1'b0),
        .AUD_READY(1'b1), .AUD_VALID(satValid), .AUD_L(satL), .AUD_R(satR),
        .OVF(satOvf), .DROP_CNT(satDrop)
    );

    always #5 MCLK = ~MCLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference model: one sample per window from plain sums, then an ideal 2-deep queue.
    int  qL[$], qR[$];
    int  mWin, mDrop;
    int  mSum [2];
    bit  mOvf;
    bit  pendV [LAT];
    int  pendS [LAT][2];
    int  xp [2], yp [2];
    int  psgPart, xv, yv;

    always @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            qL.delete();
            qR.delete();
            mWin = 0; mDrop = 0; mOvf = 1'b0;
            for (int c = 0; c < 2; c++) begin
                mSum[c] = 0; xp[c] = 0; yp[c] = 0;
            end
            for (int k = 0; k < LAT; k++) pendV[k] = 1'b0;
        end else begin
            if (qL.size() > 0 && ready) begin
                void'(qL.pop_front());
                void'(qR.pop_front());
            end
            if (pendV[LAT-1]) begin
                if (qL.size() < 2) begin
                    qL.push_back(pendS[LAT-1][0]);
                    qR.push_back(pendS[LAT-1][1]);
                end else begin
                    mOvf = 1'b1;
                    if (mDrop < 255) mDrop++;
                end
            end
            for (int k = LAT-1; k > 0; k--) begin
                pendV[k] = pendV[k-1];
                pendS[k] = pendS[k-1];
            end
            pendV[0] = 1'b0;
            mSum[0] += int'(mol);
            mSum[1] += int'(mor);
            if (mWin == P-1) begin
                psgPart = (int'(psg) * PSGG) >>> 8;
                for (int c = 0; c < 2; c++) begin
                    xv = mute ? 0 : clamp16(((mSum[c] * FMG) >>> 8) + psgPart);
`ifdef MD_AUDIO_MIXER_DC_BLOCK_EN
                    yv = clamp16(xv - xp[c] + yp[c] - (yp[c] >>> 8));
                    xp[c] = xv;
                    yp[c] = yv;
                    xv = yv;
`endif
                    pendS[0][c] = xv;
                    mSum[c] = 0;
                end
                pendV[0] = 1'b1;
                mWin = 0;
            end else begin
                mWin++;
            end
        end
    end

    always @(negedge MCLK) begin
        if (chkEn && SRES) begin
            checkOutput("mdlValid", int'(audValid), (qL.size() > 0) ? 1 : 0);
            if (qL.size() > 0) begin
                checkOutput("mdlL", int'(audL), qL[0]);
                checkOutput("mdlR", int'(audR), qR[0]);
            end
            checkOutput("mdlOvf", int'(ovf), int'(mOvf));
            checkOutput("mdlDrop", int'(dropCnt), mDrop);
        end
    end

    typedef struct {
        int mol; int mor; int psg; int mute; int expL; int expR;
    } vec_t;
    vec_t vecs [8];

    task automatic applyStimulus(input int m0, input int m1, input int p, input int mu);
        mol  = 9'(m0);
        mor  = 9'(m1);
        psg  = 16'(p);
        mute = (mu != 0);
    endtask

    task automatic resetDut();
        SRES = 1'b0;
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        checkOutput("rstValid", int'(audValid), 0);
        checkOutput("rstL", int'(audL), 0);
        checkOutput("rstR", int'(audR), 0);
        checkOutput("rstOvf", int'(ovf), 0);
        checkOutput("rstDrop", int'(dropCnt), 0);
        @(posedge MCLK);
        #1 SRES = 1'b1;
    endtask

    task automatic checkSample(input int i);
        checkOutput($sformatf("tblValid%0d", i), int'(audValid), 1);
        checkOutput($sformatf("tblL%0d", i), int'(audL), vecs[i].expL);
        checkOutput($sformatf("tblR%0d", i), int'(audR), vecs[i].expR);
    endtask

    initial begin
        vecs[0] = '{100,  100,  'h0000, 0,  1800,  1800};
        vecs[1] = '{-100, 0,    'h1000, 0,  -776,  1024};
        vecs[2] = '{255,  -256, 'h0000, 0,  4590,  -4608};
        vecs[3] = '{0,    0,    'hFFFF, 0,  16383, 16383};
        vecs[4] = '{100,  100,  'h0000, 1,  0,     0};
        vecs[5] = '{-1,   1,    'h0001, 0,  -18,   18};
        vecs[6] = '{-7,   255,  'h8003, 0,  8066,  12782};
        vecs[7] = '{0,    0,    'h0000, 0,  0,     0};
        satMol = 9'h0FF;
        satMor = 9'h100;
        ready  = 1'b1;
        chkEn  = 1'b1;

`ifndef MD_AUDIO_MIXER_DC_BLOCK_EN
        applyStimulus(vecs[0].mol, vecs[0].mor, vecs[0].psg, vecs[0].mute);
        resetDut();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                repeat (P) @(posedge MCLK);
            end else begin
                applyStimulus(vecs[i].mol, vecs[i].mor, vecs[i].psg, vecs[i].mute);
                repeat (2) @(posedge MCLK);
                @(negedge MCLK);
                checkSample(i - 1);
                if (i == 1) begin
                    checkOutput("satValid", int'(satValid), 1);
                    checkOutput("satL", int'(satL), 32767);
                    checkOutput("satR", int'(satR), -32768);
                    checkOutput("satOvf", int'(satOvf), 0);
                    checkOutput("satDrop", int'(satDrop), 0);
                end
                repeat (P - 2) @(posedge MCLK);
            end
            #1;
        end
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        checkSample(7);

        // Back-pressure: four windows with the sink stalled, then drain.
        ready = 1'b0;
        applyStimulus(10, -10, 0, 0);
        resetDut();
        for (int w = 0; w < 4; w++) begin
            applyStimulus(10 * (w + 1), -10 * (w + 1), 0, 0);
            repeat (P) @(posedge MCLK);
            #1;
        end
        applyStimulus(100, 100, 0, 0);
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        checkOutput("bpValid", int'(audValid), 1);
        checkOutput("bpHeadL", int'(audL), 180);
        checkOutput("bpHeadR", int'(audR), -180);
        checkOutput("bpOvf", int'(ovf), 1);
        checkOutput("bpDrop", int'(dropCnt), 2);
        ready = 1'b1;
        @(negedge MCLK);
        checkOutput("drainValid", int'(audValid), 1);
        checkOutput("drainL", int'(audL), 360);
        checkOutput("drainR", int'(audR), -360);
        @(negedge MCLK);
        checkOutput("drainEmpty", int'(audValid), 0);

        // Asynchronous reset mid-window, then a full period before the next sample.
        @(posedge MCLK);
        #3 SRES = 1'b0;
        #1;
        checkOutput("asyncValid", int'(audValid), 0);
        checkOutput("asyncL", int'(audL), 0);
        checkOutput("asyncOvf", int'(ovf), 0);
        checkOutput("asyncDrop", int'(dropCnt), 0);
        @(posedge MCLK);
        #1 SRES = 1'b1;
        repeat (P + 1) @(posedge MCLK);
        @(negedge MCLK);
        checkOutput("relEarly", int'(audValid), 0);
        @(negedge MCLK);
        checkOutput("relValid", int'(audValid), 1);
        checkOutput("relL", int'(audL), 1800);
        checkOutput("relR", int'(audR), 1800);
        @(negedge MCLK);
        checkOutput("relPopped", int'(audValid), 0);
`else
        applyStimulus(100, 100, 0, 0);
        resetDut();
        repeat (P + 3) @(posedge MCLK);
        @(negedge MCLK);
        checkOutput("dcValid0", int'(audValid), 1);
        checkOutput("dcL0", int'(audL), 1800);
        repeat (P) @(posedge MCLK);
        @(negedge MCLK);
        checkOutput("dcValid1", int'(audValid), 1);
        checkOutput("dcL1", int'(audL), 1793);
`endif

        // Randomized windows with varying sink behaviour against the model.
        resetDut();
        for (int w = 0; w < 20; w++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < P; c++) begin
                @(negedge MCLK);
                mol   = 9'($urandom);
                mor   = 9'($urandom);
                psg   = 16'($urandom);
                mute  = ($urandom_range(0, 7) == 0);
                ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 7) == 0);
            end
        end
        @(negedge MCLK);
        ready = 1'b1;
        repeat (P + 10) @(negedge MCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
